// File: rtl/vend_pkg.sv
// Shared vending-machine types: coin encoding, coin values and dispenser states.
package vend_pkg;

  typedef enum logic [1:0] {
    CoinNickel  = 2'd0,
    CoinDime    = 2'd1,
    CoinQuarter = 2'd2,
    CoinDollar  = 2'd3
  } coin_e;

  localparam int unsigned NickelCents  = 5;
  localparam int unsigned DimeCents    = 10;
  localparam int unsigned QuarterCents = 25;
  localparam int unsigned DollarCents  = 100;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StGap,
    StDone,
    StJam
  } disp_state_e;

  function automatic int unsigned coin_cents(coin_e c);
    int unsigned cents;
    case (c)
      CoinNickel:  cents = NickelCents;
      CoinDime:    cents = DimeCents;
      CoinQuarter: cents = QuarterCents;
      default:     cents = DollarCents;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/acknowledge handshake between the change dispenser and the coin ejector.
interface change_dispenser_if;
  import vend_pkg::*;

  logic  eject_req;
  coin_e eject_type;
  logic  eject_ack;

  modport master (
    output eject_req,
    output eject_type,
    input  eject_ack
  );

  modport slave (
    input  eject_req,
    input  eject_type,
    output eject_ack
  );

endinterface

// File: rtl/coin_tube_counter.sv
// Per-tube coin inventory: saturating refill increment, ack decrement, simultaneous = hold.
module coin_tube_counter #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned INIT_COUNT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_W'(INIT_COUNT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer: dollars, quarters, dimes, nickels, one ejector handshake
// per coin, with per-tube inventory, shortfall reporting and ejector-timeout jam.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W          = 10,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned INIT_COUNT     = 20,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AMT_W-1:0]          change_amt,
  change_dispenser_if.master        ejector,
  input  logic                      refill_valid,
  input  logic [1:0]                refill_type,
  input  logic                      clear,
  output logic                      busy,
  output logic                      done,
  output logic                      short,
  output logic                      jam,
  output logic [AMT_W-1:0]          remaining,
  output logic [CNT_W-1:0]          inv_nickel,
  output logic [CNT_W-1:0]          inv_dime,
  output logic [CNT_W-1:0]          inv_quarter,
  output logic [CNT_W-1:0]          inv_dollar
);

  // One timer serves both the REQ timeout and the GAP settle count.
  localparam int unsigned TmrMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  coin_e            type_q, type_d;
  logic             short_q, short_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic             ack_take;

  logic [CNT_W-1:0] inv [4];
  logic             pick_ok;
  coin_e            pick_type;

  // Largest coin that fits the amount still owed and is in stock.
  always_comb begin
    pick_ok   = 1'b1;
    pick_type = CoinNickel;
    if (inv[CoinDollar] != '0 && rem_q >= AMT_W'(DollarCents)) begin
      pick_type = CoinDollar;
    end else if (inv[CoinQuarter] != '0 && rem_q >= AMT_W'(QuarterCents)) begin
      pick_type = CoinQuarter;
    end else if (inv[CoinDime] != '0 && rem_q >= AMT_W'(DimeCents)) begin
      pick_type = CoinDime;
    end else if (inv[CoinNickel] != '0 && rem_q >= AMT_W'(NickelCents)) begin
      pick_type = CoinNickel;
    end else begin
      pick_ok = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    type_d   = type_q;
    short_d  = short_q;
    timer_d  = timer_q;
    ack_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = change_amt;
          short_d = 1'b0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (pick_ok) begin
          type_d  = pick_type;
          timer_d = '0;
          state_d = StReq;
        end else begin
          short_d = 1'b1;
          state_d = StDone;
        end
      end
      StReq: begin
        if (ejector.eject_ack) begin
          ack_take = 1'b1;
          rem_d    = rem_q - AMT_W'(coin_cents(type_q));
          timer_d  = '0;
          state_d  = StGap;
        end else if (timer_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StJam;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (timer_q == TmrW'(GAP_CYCLES - 1)) begin
          state_d = StSelect;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      StJam: begin
        if (clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      type_q  <= CoinNickel;
      short_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      short_q <= short_d;
      timer_q <= timer_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_tube
    coin_tube_counter #(
      .CNT_W      (CNT_W),
      .INIT_COUNT (INIT_COUNT)
    ) u_tube (
      .clk   (clk),
      .rst   (rst),
      .inc   (refill_valid && (refill_type == 2'(i))),
      .dec   (ack_take && (type_q == coin_e'(i))),
      .count (inv[i])
    );
  end

  assign ejector.eject_req  = (state_q == StReq);
  assign ejector.eject_type = type_q;
  assign busy        = (state_q != StIdle) && (state_q != StJam);
  assign done        = (state_q == StDone);
  assign jam         = (state_q == StJam);
  assign short       = short_q;
  assign remaining   = rem_q;
  assign inv_nickel  = inv[CoinNickel];
  assign inv_dime    = inv[CoinDime];
  assign inv_quarter = inv[CoinQuarter];
  assign inv_dollar  = inv[CoinDollar];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin sequences are queued at start and
// popped as the ejector requests arrive.
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int unsigned AMT_W          = 10;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned INIT_COUNT     = 20;
  localparam int unsigned GAP_CYCLES     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 1000;
  localparam int          EvtBound       = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             refill_valid;
  logic [1:0]       refill_type;
  logic             clear;
  logic             busy, done, short, jam;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] inv_nickel, inv_dime, inv_quarter, inv_dollar;

  change_dispenser_if ej_if ();

  change_dispenser #(
    .AMT_W          (AMT_W),
    .CNT_W          (CNT_W),
    .INIT_COUNT     (INIT_COUNT),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .change_amt   (change_amt),
    .ejector      (ej_if),
    .refill_valid (refill_valid),
    .refill_type  (refill_type),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .short        (short),
    .jam          (jam),
    .remaining    (remaining),
    .inv_nickel   (inv_nickel),
    .inv_dime     (inv_dime),
    .inv_quarter  (inv_quarter),
    .inv_dollar   (inv_dollar)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    m_inv[4];
  int    cents_tab[4] = '{5, 10, 25, 100};
  coin_e exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dut_inv(input int k);
    int v;
    case (k)
      0:       v = int'(inv_nickel);
      1:       v = int'(inv_dime);
      2:       v = int'(inv_quarter);
      default: v = int'(inv_dollar);
    endcase
    return v;
  endfunction

  task automatic do_refill(input int k);
    refill_valid = 1'b1;
    refill_type  = 2'(k);
    step();
    refill_valid = 1'b0;
    if (m_inv[k] < 255) m_inv[k]++;
  endtask

  // Greedy reference for the expected coin sequence; acks are delayed ack_dly cycles and
  // optionally collide with a refill of the same tube.
  task automatic run_dispense(input int amt, input int ack_dly, input bit collide);
    int    inv_c[4];
    int    exp_rem, rem_run, steps;
    bit    exp_short, found, first;
    coin_e t;
    inv_c     = m_inv;
    exp_rem   = amt;
    exp_short = 1'b0;
    exp_q.delete();
    while (exp_rem > 0 && !exp_short) begin
      found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
        if (!found && inv_c[k] > 0 && exp_rem >= cents_tab[k]) begin
          found = 1'b1;
          exp_q.push_back(coin_e'(k));
          inv_c[k]--;
          exp_rem -= cents_tab[k];
        end
      end
      if (!found) exp_short = 1'b1;
    end
    rem_run    = amt;
    change_amt = AMT_W'(amt);
    start      = 1'b1;
    step();
    start = 1'b0;
    steps = 1;
    first = 1'b1;
    while (1) begin
      while (!ej_if.eject_req && !done && steps < EvtBound) begin
        step();
        steps++;
      end
      if (steps >= EvtBound) begin
        check("event_bound", steps, 0);
        return;
      end
      check(first ? "first_event_lat" : "coin_period", steps, first ? 2 : GAP_CYCLES + 2);
      first = 1'b0;
      if (done) begin
        check("done_queue_empty", exp_q.size(), 0);
        check("done_short", int'(short), int'(exp_short));
        check("done_remaining", int'(remaining), exp_rem);
        step();
        check("done_one_cycle", int'(done), 0);
        check("idle_not_busy", int'(busy), 0);
        return;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_req", 1, 0);
        return;
      end
      t = exp_q.pop_front();
      check("eject_type", int'(ej_if.eject_type), int'(t));
      repeat (ack_dly) step();
      check("type_stable", int'(ej_if.eject_type), int'(t));
      ej_if.eject_ack = 1'b1;
      if (collide) begin
        refill_valid = 1'b1;
        refill_type  = 2'(int'(t));
      end
      step();
      ej_if.eject_ack = 1'b0;
      refill_valid    = 1'b0;
      if (!collide) m_inv[int'(t)]--;
      rem_run -= cents_tab[int'(t)];
      check("req_drop", int'(ej_if.eject_req), 0);
      check("inv_after_ack", dut_inv(int'(t)), m_inv[int'(t)]);
      check("rem_after_ack", int'(remaining), rem_run);
      steps = 1;
    end
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    change_amt      = '0;
    refill_valid    = 1'b0;
    refill_type     = 2'd0;
    clear           = 1'b0;
    ej_if.eject_ack = 1'b0;
    for (int k = 0; k < 4; k++) m_inv[k] = INIT_COUNT;
    step();
    step();
    rst = 1'b0;

    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(ej_if.eject_req), 0);
    check("rst_done", int'(done), 0);
    check("rst_short", int'(short), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_type", int'(ej_if.eject_type), 0);
    check("rst_remaining", int'(remaining), 0);
    for (int k = 0; k < 4; k++) check("rst_inv", dut_inv(k), INIT_COUNT);

    // 65 cents: quarter, quarter, dime, nickel.
    run_dispense(65, 3, 1'b0);
    check("n65_short", int'(short), 0);
    check("n65_quarter", int'(inv_quarter), 18);
    check("n65_dime", int'(inv_dime), 19);
    check("n65_nickel", int'(inv_nickel), 19);
    check("n65_dollar", int'(inv_dollar), 20);

    run_dispense(0, 0, 1'b0);

    // Drain nickel and dime tubes, then 30 cents ends short by a nickel.
    while (m_inv[0] > 0) run_dispense(5, 0, 1'b0);
    while (m_inv[1] > 0) run_dispense(10, 0, 1'b0);
    check("drained_nickel", int'(inv_nickel), 0);
    check("drained_dime", int'(inv_dime), 0);
    run_dispense(30, 2, 1'b0);
    check("short30_flag", int'(short), 1);
    check("short30_rem", int'(remaining), 5);
    run_dispense(3, 0, 1'b0);
    check("short3_rem", int'(remaining), 3);

    do_refill(1);
    do_refill(1);
    check("refill_dime", int'(inv_dime), 2);
    run_dispense(10, 1, 1'b1);
    check("collide_dime", int'(inv_dime), 2);
    repeat (300) do_refill(3);
    check("sat_dollar", int'(inv_dollar), 255);

    // Jam: no ack for TIMEOUT_CYCLES, a stray start in REQ is ignored.
    change_amt = AMT_W'(100);
    start      = 1'b1;
    step();
    start = 1'b0;
    step();
    check("jam_req_up", int'(ej_if.eject_req), 1);
    change_amt = AMT_W'(5);
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (TIMEOUT_CYCLES - 2) step();
    check("jam_early", int'(jam), 0);
    check("jam_early_req", int'(ej_if.eject_req), 1);
    step();
    check("jam_set", int'(jam), 1);
    check("jam_req_low", int'(ej_if.eject_req), 0);
    check("jam_busy", int'(busy), 0);
    check("jam_inv", int'(inv_dollar), m_inv[3]);
    check("jam_rem", int'(remaining), 100);
    ej_if.eject_ack = 1'b1;
    step();
    ej_if.eject_ack = 1'b0;
    check("jam_ack_ignored", int'(inv_dollar), m_inv[3]);
    check("jam_sticky", int'(jam), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_jam", int'(jam), 0);
    check("clear_idle", int'(busy), 0);
    check("clear_rem_kept", int'(remaining), 100);
    run_dispense(25, 1, 1'b0);
    check("after_jam_short", int'(short), 0);

    // Reset while in REQ.
    change_amt = AMT_W'(100);
    start      = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_req_up", int'(ej_if.eject_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) m_inv[k] = INIT_COUNT;
    check("mid_rst_req", int'(ej_if.eject_req), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rem", int'(remaining), 0);
    for (int k = 0; k < 4; k++) check("mid_rst_inv", dut_inv(k), INIT_COUNT);
    run_dispense(65, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
